// File: rtl/alu_opa_fwd_reg_if.sv
// alu_opa_fwd_reg_if: operand-A selector bus (sources, forwarding taps, registered result)
interface alu_opa_fwd_reg_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int CW    = 16
);
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [SELW-1:0]       sel;
    logic [NSRC*WIDTH-1:0] src_bus;
    logic [4:0]            rs_addr;
    logic                  exm_wen;
    logic [4:0]            exm_waddr;
    logic [WIDTH-1:0]      exm_wdata;
    logic                  mwb_wen;
    logic [4:0]            mwb_waddr;
    logic [WIDTH-1:0]      mwb_wdata;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [1:0]            out_fwd;
    logic [CW-1:0]         fwd_count;
    modport master (
        output in_valid, stall, flush, sel, src_bus, rs_addr,
               exm_wen, exm_waddr, exm_wdata, mwb_wen, mwb_waddr, mwb_wdata,
        input  out_data, out_valid, out_fwd, fwd_count
    );
    modport slave (
        input  in_valid, stall, flush, sel, src_bus, rs_addr,
               exm_wen, exm_waddr, exm_wdata, mwb_wen, mwb_waddr, mwb_wdata,
        output out_data, out_valid, out_fwd, fwd_count
    );
endinterface

// File: rtl/alu_opa_fwd_reg.sv
// alu_opa_fwd_reg: ALU operand-A source mux with EX/MEM and MEM/WB forwarding on slot 0,
// registered into the ID/EX slot with stall/flush/valid and a saturating forward counter.
module alu_opa_fwd_reg #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int CW    = 16
) (
    input logic              clk,
    input logic              rst,
    alu_opa_fwd_reg_if.slave bus
);
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] mux_data;
    logic [1:0]       mux_fwd;
    logic             exm_hit;
    logic             mwb_hit;
    logic             load;
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;
    logic [1:0]       out_fwd_d, out_fwd_q;
    logic [CW-1:0]    fwd_count_d, fwd_count_q;
    assign sel = bus.sel;
    always_comb begin
        src_data    = 32'(sel) >= NSRC ? '0 : bus.src_bus[32'(sel)*WIDTH +: WIDTH];
        exm_hit     = bus.exm_wen && bus.exm_waddr != 5'd0 && bus.exm_waddr == bus.rs_addr;
        mwb_hit     = bus.mwb_wen && bus.mwb_waddr != 5'd0 && bus.mwb_waddr == bus.rs_addr;
        // only the register-file slot is forwardable; EX/MEM is the younger result
        mux_fwd     = sel != '0 ? 2'b00 : exm_hit ? 2'b01 : mwb_hit ? 2'b10 : 2'b00;
        mux_data    = mux_fwd == 2'b01 ? bus.exm_wdata : mux_fwd == 2'b10 ? bus.mwb_wdata : src_data;
        load        = !bus.flush && !bus.stall;
        out_data_d  = bus.flush ? '0 : load && bus.in_valid ? mux_data : out_data_q;
        out_valid_d = bus.flush ? 1'b0 : load ? bus.in_valid : out_valid_q;
        out_fwd_d   = bus.flush ? 2'b00 : load ? (bus.in_valid ? mux_fwd : 2'b00) : out_fwd_q;
        fwd_count_d = load && bus.in_valid && mux_fwd != 2'b00 && fwd_count_q != '1
                      ? fwd_count_q + 1'b1 : fwd_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_fwd_q   <= 2'b00;
            fwd_count_q <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_fwd_q   <= out_fwd_d;
            fwd_count_q <= fwd_count_d;
        end
    end
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_fwd   = out_fwd_q;
    assign bus.fwd_count = fwd_count_q;
endmodule
